// File: rtl/arcadia_ioctl_pkg.sv
// Shared types and constants for the ioctl download streamer.
package arcadia_ioctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    FETCH,
    WRITE,
    NEXT,
    CLOSE
  } stream_state_t;

  localparam int unsigned IOCTL_ADDR_W = 25;
  localparam logic [7:0]  CART_INDEX   = 8'd1;

endpackage

// File: rtl/arcadia_rd_delay.sv
// RD_LAT-deep shift of a BRAM read strobe; cap marks the cycle the read data is valid.
module arcadia_rd_delay #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic rd,
  output logic cap
);

  logic [RD_LAT-1:0] pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= rd;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign cap = pipe[RD_LAT-1];

endmodule

// File: rtl/arcadia_ioctl_streamer.sv
// Replays a local ROM image as an ioctl download stream, honouring ioctl_wait.
// Optional additive checksum output enabled by ARCADIA_STREAM_CKSUM_EN.
module arcadia_ioctl_streamer
  import arcadia_ioctl_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned RD_LAT = 1,
  parameter logic [7:0]  INDEX  = CART_INDEX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W:0]         len,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_rd,
  input  logic [7:0]              mem_data,
  output logic                    ioctl_download,
  output logic [7:0]              ioctl_index,
  output logic                    ioctl_wr,
  output logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  output logic [7:0]              ioctl_dout,
  input  logic                    ioctl_wait
`ifdef ARCADIA_STREAM_CKSUM_EN
  ,
  output logic [7:0]              cksum
`endif
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  stream_state_t   state, state_nx;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] len_q;
  logic [1:0]      lat_cnt;
  logic [7:0]      dout_q;
  logic            zero_done;
  logic            cap;
  logic            accept;
  logic            last;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == len_q - 1'b1);

  arcadia_rd_delay #(
    .RD_LAT (RD_LAT)
  ) u_rd_delay (
    .clk   (clk),
    .reset (reset),
    .rd    (mem_rd),
    .cap   (cap)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start && len != '0) state_nx = OPEN;
      OPEN:    state_nx = FETCH;
      FETCH:   if (lat_cnt == LAT_LAST) state_nx = WRITE;
      WRITE:   if (!ioctl_wait) state_nx = NEXT;
      NEXT:    state_nx = last ? CLOSE : FETCH;
      CLOSE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      lat_cnt   <= '0;
      dout_q    <= '0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_nx;
      zero_done <= accept && (len == '0);
      lat_cnt   <= (state == FETCH) ? lat_cnt + 2'd1 : 2'd0;
      if (cap) dout_q <= mem_data;
      if (accept) begin
        cnt   <= '0;
        len_q <= len;
      end else if (state == NEXT && !last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // WRITE is entered on the capture cycle, so the byte is forwarded straight
  // from mem_data then held from dout_q; the value seen by the sink never changes.
  assign ioctl_dout     = cap ? mem_data : dout_q;
  assign busy           = (state != IDLE);
  assign done           = (state == CLOSE) || zero_done;
  assign ioctl_download = state inside {OPEN, FETCH, WRITE, NEXT};
  assign ioctl_index    = ioctl_download ? INDEX : '0;
  assign mem_rd         = (state == FETCH) && (lat_cnt == '0);
  assign mem_addr       = cnt[ADDR_W-1:0];
  assign ioctl_wr       = (state == WRITE) && !ioctl_wait;
  assign ioctl_addr     = IOCTL_ADDR_W'(cnt);

`ifdef ARCADIA_STREAM_CKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cksum <= '0;
    end else if (accept) begin
      cksum <= '0;
    end else if (ioctl_wr) begin
      cksum <= cksum + ioctl_dout;
    end
  end
`endif

endmodule

// File: tb/tb_arcadia_ioctl_streamer.sv
// Randomized self-checking bench for arcadia_ioctl_streamer against a cycle-level stream model.
module tb_arcadia_ioctl_streamer;
  import arcadia_ioctl_pkg::*;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned RD_LAT = 1;

  typedef logic [ADDR_W:0] len_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  len_t                    len = '0;
  logic                    busy, done, mem_rd, ioctl_download, ioctl_wr;
  logic [ADDR_W-1:0]       mem_addr;
  logic [7:0]              mem_data, ioctl_index, ioctl_dout;
  logic [IOCTL_ADDR_W-1:0] ioctl_addr;
  logic                    ioctl_wait = 1'b0;
`ifdef ARCADIA_STREAM_CKSUM_EN
  logic [7:0]              cksum;
`endif

  arcadia_ioctl_streamer #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .INDEX  (8'd1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .len            (len),
    .busy           (busy),
    .done           (done),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_data       (mem_data),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait)
`ifdef ARCADIA_STREAM_CKSUM_EN
    ,
    .cksum          (cksum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source ROM with one cycle of read latency.
  logic [7:0] mem [16];
  logic [7:0] mem_q;
  always @(posedge clk) if (mem_rd) mem_q <= mem[mem_addr];
  assign mem_data = mem_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: sampled late in each cycle, after inputs have settled.
  int   wr_c[$], wr_a[$], wr_d[$], done_c[$], dl_rise[$], dl_fall[$];
  int   rd_n = 0;
  logic dl_prev = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (ioctl_wr) begin
      wr_c.push_back(cyc);
      wr_a.push_back(int'(ioctl_addr));
      wr_d.push_back(int'(ioctl_dout));
      check("wr_vs_wait", ioctl_wait, 0);
      check("wr_in_window", ioctl_download, 1);
      check("wr_index", ioctl_index, 8'd1);
    end
    if (done) done_c.push_back(cyc);
    if (mem_rd) rd_n++;
    if (ioctl_download && !dl_prev) dl_rise.push_back(cyc);
    if (!ioctl_download && dl_prev) dl_fall.push_back(cyc);
    dl_prev = ioctl_download;
  end

  bit wmask [400];

  task automatic clear_mask();
    foreach (wmask[k]) wmask[k] = 1'b0;
  endtask

  // Model: byte i is ready 3 cycles after start (or after the previous write)
  // and is written at the first ready cycle with wait low.
  task automatic run_stream(input int L, input int restart_k, input int rst_k);
    int w [16];
    int hold_idx [400];
    int r, c, done_k, end_k, s, exp_n, exp_done, sum;
    foreach (hold_idx[k]) hold_idx[k] = -1;
    r = 3;
    for (int i = 0; i < L; i++) begin
      c = r;
      while (wmask[c]) c++;
      w[i] = c;
      for (int h = r; h < c; h++) hold_idx[h] = i;
      r = c + 3;
    end
    done_k   = (L == 0) ? 1 : w[L-1] + 2;
    end_k    = (rst_k >= 0) ? rst_k + 4 : done_k + 4;
    exp_n    = 0;
    for (int i = 0; i < L; i++) if (rst_k < 0 || w[i] <= rst_k) exp_n++;
    exp_done = (rst_k < 0 || done_k <= rst_k) ? 1 : 0;
    s = 0;
    wr_c.delete(); wr_a.delete(); wr_d.delete();
    done_c.delete(); dl_rise.delete(); dl_fall.delete();
    rd_n = 0;

    for (int k = 0; k <= end_k; k++) begin
      @(negedge clk);
      if (k == 0) s = cyc;
      start      = (k == 0) || (k == restart_k);
      len        = (k == 0) ? len_t'(L) : len_t'($urandom);
      reset      = (k == rst_k);
      ioctl_wait = wmask[k];
      #2;
      if (hold_idx[k] >= 0 && (rst_k < 0 || k <= rst_k)) begin
        check("hold_wr", ioctl_wr, 0);
        check("hold_addr", ioctl_addr, hold_idx[k]);
        check("hold_dout", ioctl_dout, mem[hold_idx[k]]);
      end
      if (rst_k >= 0 && k == rst_k + 1) begin
        check("rst_download", ioctl_download, 0);
        check("rst_wr", ioctl_wr, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", ioctl_addr, 0);
        check("rst_done", done, 0);
      end
    end
    start      = 1'b0;
    ioctl_wait = 1'b0;
    reset      = 1'b0;

    check("n_wr", wr_c.size(), exp_n);
    for (int i = 0; i < exp_n && i < wr_c.size(); i++) begin
      check("wr_addr", wr_a[i], i);
      check("wr_data", wr_d[i], mem[i]);
      check("wr_cycle", wr_c[i] - s, w[i]);
    end
    check("n_done", done_c.size(), exp_done);
    if (exp_done == 1 && done_c.size() > 0) check("done_cycle", done_c[0] - s, done_k);
    if (L == 0) begin
      check("dl_never", dl_rise.size(), 0);
    end else begin
      check("dl_rise", (dl_rise.size() > 0) ? dl_rise[0] - s : -1, 1);
      check("dl_fall", (dl_fall.size() > 0) ? dl_fall[0] - s : -1,
            (exp_done == 1) ? done_k : rst_k + 1);
    end
    if (rst_k < 0) check("n_rd", rd_n, L);
    check("idle_busy", busy, 0);
`ifdef ARCADIA_STREAM_CKSUM_EN
    if (rst_k < 0) begin
      sum = 0;
      for (int i = 0; i < L; i++) sum += int'(mem[i]);
      check("cksum", cksum, sum % 256);
    end
`endif
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    clear_mask();
    repeat (3) @(negedge clk);
    #2;
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_mem_rd0", mem_rd, 0);
    check("rst_dl0", ioctl_download, 0);
    check("rst_wr0", ioctl_wr, 0);
    check("rst_mem_addr0", mem_addr, 0);
    check("rst_ioaddr0", ioctl_addr, 0);
    check("rst_dout0", ioctl_dout, 0);
    check("rst_index0", ioctl_index, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    mem[0] = 8'hA5;
    run_stream(1, -1, -1);

    for (int i = 0; i < 16; i++) mem[i] = 8'(i) ^ 8'h5A;
    run_stream(16, -1, -1);

    for (int k = 9; k < 14; k++) wmask[k] = 1'b1;
    run_stream(16, -1, -1);
    clear_mask();

    run_stream(0, -1, -1);
    run_stream(8, 10, -1);

    run_stream(8, -1, 14);
    run_stream(4, -1, -1);

    for (int it = 0; it < 25; it++) begin
      int L;
      int rk;
      foreach (mem[i]) mem[i] = 8'($urandom);
      clear_mask();
      for (int k = 0; k < 200; k++) wmask[k] = ($urandom_range(0, 3) == 0);
      L  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16));
      rk = (L > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3 * L)) : -1;
      run_stream(L, rk, -1);
    end
    clear_mask();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
